mem_port_arbiter: RTL and testbench

// - Shares one single-ported unified memory between the core's instruction-fetch port and its data (load/store) port.
// - Sits between the core and the memory. The core stalls on each port until that port's o_*_valid pulses.
// - Arbitration is round-robin with one outstanding transaction. A timeout watchdog turns a hung access into an error completion.

---
 rtl/mem_port_arbiter_pkg.sv | 27 ++
 rtl/mem_port_arbiter_rr_arbiter_2.sv | 45 ++++
 rtl/mem_port_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the fetch/data memory port arbiter: bus widths, FSM states
// and port identifiers.
package mem_port_arbiter_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_DM = 1'b1
  } port_id_t;

  // Grant vectors are indexed by port id: bit 0 = fetch, bit 1 = data.
  function automatic port_id_t gnt_to_port(input logic [1:0] gnt);
    return gnt[1] ? PORT_DM : PORT_IF;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arbiter_2.sv
// Two-way round-robin arbiter: masked requests in, one-hot grant out, with the
// last-granted port remembered so a tie goes to the other requester.
module rr_arbiter_2
  import mem_port_arbiter_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic [1:0] i_req,
  input  logic [1:0] i_mask,
  input  logic       i_upd,
  output logic [1:0] o_gnt
);

  port_id_t   last_q;
  port_id_t   last_d;
  logic [1:0] eff_req;

  always_comb begin
    eff_req = i_req & ~i_mask;
    o_gnt   = 2'b00;
    case (eff_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = (last_q == PORT_DM) ? 2'b01 : 2'b10;
      default: o_gnt = 2'b00;
    endcase
  end

  always_comb begin
    last_d = last_q;
    if (i_upd && (o_gnt != 2'b00)) begin
      last_d = gnt_to_port(o_gnt);
    end
  end

  // Reset to DM so that fetch wins the first tie.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      last_q <= PORT_DM;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the instruction-fetch and data ports:
// round-robin grant, one outstanding access, watchdog turns a hung access into an error completion.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic  i_clk,
  input  logic  i_rstn,
  input  logic  i_if_req,
  input  addr_t i_if_addr,
  output logic  o_if_valid,
  output data_t o_if_rdata,
  input  logic  i_dm_req,
  input  logic  i_dm_wen,
  input  addr_t i_dm_addr,
  input  data_t i_dm_wd,
  output logic  o_dm_valid,
  output data_t o_dm_rdata,
  output logic  o_err,
  output logic  o_mem_req,
  output logic  o_mem_wen,
  output addr_t o_mem_addr,
  output data_t o_mem_wd,
  input  logic  i_mem_ack,
  input  data_t i_mem_rdata
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_t       state_q,    state_d;
  port_id_t         port_q,     port_d;
  addr_t            addr_q,     addr_d;
  data_t            wd_q,       wd_d;
  logic             wen_q,      wen_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic             if_vld_q,   if_vld_d;
  logic             dm_vld_q,   dm_vld_d;
  logic             err_q,      err_d;
  data_t            if_rdata_q, if_rdata_d;
  data_t            dm_rdata_q, dm_rdata_d;

  logic [1:0] gnt;
  logic       arb_upd;
  logic       done;
  logic       timed_out;
  data_t      ret_data;

  // A port whose completion pulse is out this cycle still holds its old request.
  rr_arbiter_2 u_rr (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .i_req  ({i_dm_req, i_if_req}),
    .i_mask ({dm_vld_q, if_vld_q}),
    .i_upd  (arb_upd),
    .o_gnt  (gnt)
  );

  always_comb begin
    state_d    = state_q;
    port_d     = port_q;
    addr_d     = addr_q;
    wd_d       = wd_q;
    wen_d      = wen_q;
    cnt_d      = cnt_q;
    if_vld_d   = 1'b0;
    dm_vld_d   = 1'b0;
    err_d      = 1'b0;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    arb_upd    = 1'b0;
    done       = 1'b0;
    timed_out  = 1'b0;

    case (state_q)
      IDLE: begin
        arb_upd = 1'b1;
        if (gnt != 2'b00) begin
          port_d  = gnt_to_port(gnt);
          addr_d  = gnt[1] ? i_dm_addr : i_if_addr;
          wd_d    = gnt[1] ? i_dm_wd : '0;
          wen_d   = gnt[1] & i_dm_wen;
          cnt_d   = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (i_mem_ack) begin
          done = 1'b1;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (i_mem_ack) begin
          done = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          timed_out = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Stores and timed-out accesses return zero rather than whatever is on the bus.
    ret_data = (timed_out || wen_q) ? '0 : i_mem_rdata;
    if (done || timed_out) begin
      state_d = IDLE;
      err_d   = timed_out;
      if (port_q == PORT_IF) begin
        if_vld_d   = 1'b1;
        if_rdata_d = ret_data;
      end else begin
        dm_vld_d   = 1'b1;
        dm_rdata_d = ret_data;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q    <= IDLE;
      port_q     <= PORT_IF;
      addr_q     <= '0;
      wd_q       <= '0;
      wen_q      <= 1'b0;
      cnt_q      <= '0;
      if_vld_q   <= 1'b0;
      dm_vld_q   <= 1'b0;
      err_q      <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      port_q     <= port_d;
      addr_q     <= addr_d;
      wd_q       <= wd_d;
      wen_q      <= wen_d;
      cnt_q      <= cnt_d;
      if_vld_q   <= if_vld_d;
      dm_vld_q   <= dm_vld_d;
      err_q      <= err_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  assign o_mem_req  = (state_q == ISSUE);
  assign o_mem_wen  = wen_q;
  assign o_mem_addr = addr_q;
  assign o_mem_wd   = wd_q;
  assign o_if_valid = if_vld_q;
  assign o_if_rdata = if_rdata_q;
  assign o_dm_valid = dm_vld_q;
  assign o_dm_rdata = dm_rdata_q;
  assign o_err      = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, store, contention, stale mask,
// timeout and mid-access reset, with hand-computed expectations.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int TIMEOUT = 16;

  logic  clk = 1'b0;
  logic  rstn;
  logic  if_req;
  addr_t if_addr;
  logic  if_valid;
  data_t if_rdata;
  logic  dm_req;
  logic  dm_wen;
  addr_t dm_addr;
  data_t dm_wd;
  logic  dm_valid;
  data_t dm_rdata;
  logic  err;
  logic  mem_req;
  logic  mem_wen;
  addr_t mem_addr;
  data_t mem_wd;
  logic  mem_ack;
  data_t mem_rdata;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .i_clk       (clk),
    .i_rstn      (rstn),
    .i_if_req    (if_req),
    .i_if_addr   (if_addr),
    .o_if_valid  (if_valid),
    .o_if_rdata  (if_rdata),
    .i_dm_req    (dm_req),
    .i_dm_wen    (dm_wen),
    .i_dm_addr   (dm_addr),
    .i_dm_wd     (dm_wd),
    .o_dm_valid  (dm_valid),
    .o_dm_rdata  (dm_rdata),
    .o_err       (err),
    .o_mem_req   (mem_req),
    .o_mem_wen   (mem_wen),
    .o_mem_addr  (mem_addr),
    .o_mem_wd    (mem_wd),
    .i_mem_ack   (mem_ack),
    .i_mem_rdata (mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_req"},  32'(mem_req),  32'h0);
    chk({tag, "_mem_wen"},  32'(mem_wen),  32'h0);
    chk({tag, "_mem_addr"}, mem_addr,      32'h0);
    chk({tag, "_mem_wd"},   mem_wd,        32'h0);
    chk({tag, "_if_valid"}, 32'(if_valid), 32'h0);
    chk({tag, "_dm_valid"}, 32'(dm_valid), 32'h0);
    chk({tag, "_err"},      32'(err),      32'h0);
    chk({tag, "_if_rdata"}, if_rdata,      32'h0);
    chk({tag, "_dm_rdata"}, dm_rdata,      32'h0);
  endtask

  initial begin
    rstn      = 1'b0;
    if_req    = 1'b0;
    if_addr   = '0;
    dm_req    = 1'b0;
    dm_wen    = 1'b0;
    dm_addr   = '0;
    dm_wd     = '0;
    mem_ack   = 1'b0;
    mem_rdata = '0;

    // Reset state
    step();
    step();
    chk_all_zero("reset");
    rstn = 1'b1;

    // Lone fetch, acked in ISSUE; if_req held through the valid cycle
    if_req  = 1'b1;
    if_addr = 32'h40;
    step();
    chk("fetch_mem_req",  32'(mem_req), 32'h1);
    chk("fetch_mem_addr", mem_addr,     32'h40);
    chk("fetch_mem_wen",  32'(mem_wen), 32'h0);
    mem_ack   = 1'b1;
    mem_rdata = 32'h00500093;
    step();
    chk("fetch_valid",   32'(if_valid), 32'h1);
    chk("fetch_rdata",   if_rdata,      32'h00500093);
    chk("fetch_err",     32'(err),      32'h0);
    chk("fetch_dm_vld",  32'(dm_valid), 32'h0);
    mem_ack = 1'b0;
    step();
    chk("stale_no_reissue", 32'(mem_req),  32'h0);
    chk("stale_valid_drop", 32'(if_valid), 32'h0);
    chk("fetch_rdata_hold", if_rdata,      32'h00500093);

    // Store acked in the third WAIT cycle
    if_req  = 1'b0;
    dm_req  = 1'b1;
    dm_wen  = 1'b1;
    dm_addr = 32'h100;
    dm_wd   = 32'hDEADBEEF;
    step();
    chk("store_mem_req", 32'(mem_req), 32'h1);
    chk("store_mem_wen", 32'(mem_wen), 32'h1);
    chk("store_addr",    mem_addr,     32'h100);
    chk("store_wd",      mem_wd,       32'hDEADBEEF);
    step();
    chk("store_wait_req", 32'(mem_req), 32'h0);
    step();
    step();
    chk("store_wd_held",  mem_wd,       32'hDEADBEEF);
    chk("store_wen_held", 32'(mem_wen), 32'h1);
    chk("store_no_early", 32'(dm_valid), 32'h0);
    mem_ack   = 1'b1;
    mem_rdata = 32'h12345678;
    step();
    chk("store_valid", 32'(dm_valid), 32'h1);
    chk("store_rdata", dm_rdata,      32'h0);
    chk("store_err",   32'(err),      32'h0);
    dm_req  = 1'b0;
    dm_wen  = 1'b0;
    mem_ack = 1'b0;

    // Ack while IDLE is ignored
    step();
    mem_ack = 1'b1;
    step();
    chk("idle_ack_ifv", 32'(if_valid), 32'h0);
    chk("idle_ack_dmv", 32'(dm_valid), 32'h0);
    chk("idle_ack_req", 32'(mem_req),  32'h0);

    // Contention: both held, memory acks in every ISSUE
    if_req  = 1'b1;
    if_addr = 32'h200;
    dm_req  = 1'b1;
    dm_addr = 32'h300;
    step();
    chk("cont1_req",  32'(mem_req), 32'h1);
    chk("cont1_addr", mem_addr,     32'h200);
    mem_rdata = 32'h11;
    step();
    chk("cont1_ifv",   32'(if_valid), 32'h1);
    chk("cont1_rdata", if_rdata,      32'h11);
    step();
    chk("cont2_addr", mem_addr,     32'h300);
    chk("cont2_wen",  32'(mem_wen), 32'h0);
    mem_rdata = 32'h22;
    step();
    chk("cont2_dmv",   32'(dm_valid), 32'h1);
    chk("cont2_rdata", dm_rdata,      32'h22);
    step();
    chk("cont3_addr", mem_addr, 32'h200);
    mem_rdata = 32'h33;
    step();
    chk("cont3_ifv",   32'(if_valid), 32'h1);
    chk("cont3_rdata", if_rdata,      32'h33);
    step();
    chk("cont4_addr", mem_addr, 32'h300);
    mem_rdata = 32'h44;
    if_req    = 1'b0;
    dm_req    = 1'b0;
    step();
    chk("cont4_dmv",   32'(dm_valid), 32'h1);
    chk("cont4_rdata", dm_rdata,      32'h44);
    mem_ack = 1'b0;
    step();
    chk("cont_quiet", 32'(mem_req), 32'h0);

    // Timeout on a data load
    dm_req    = 1'b1;
    dm_wen    = 1'b0;
    dm_addr   = 32'h400;
    mem_rdata = 32'hBAD;
    step();
    chk("to_issue", 32'(mem_req), 32'h1);
    chk("to_addr",  mem_addr,     32'h400);
    for (int k = 1; k <= TIMEOUT; k++) begin
      step();
      chk("to_early", 32'({dm_valid, err}), 32'h0);
    end
    step();
    chk("to_valid", 32'(dm_valid), 32'h1);
    chk("to_err",   32'(err),      32'h1);
    chk("to_rdata", dm_rdata,      32'h0);
    chk("to_if_rdata_hold", if_rdata, 32'h33);
    dm_req = 1'b0;
    step();
    chk("to_pulse_end", 32'({dm_valid, err}), 32'h0);

    // Reset during a fetch in WAIT, then a late ack
    if_req  = 1'b1;
    if_addr = 32'h500;
    step();
    chk("rst_issue_addr", mem_addr, 32'h500);
    step();
    #2;
    rstn = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    if_req = 1'b0;
    #1;
    rstn      = 1'b1;
    mem_ack   = 1'b1;
    mem_rdata = 32'h77;
    step();
    chk("late_ack_ifv", 32'(if_valid), 32'h0);
    chk("late_ack_dmv", 32'(dm_valid), 32'h0);
    chk("late_ack_req", 32'(mem_req),  32'h0);
    mem_ack = 1'b0;
    step();
    chk("late_ack_ifv2", 32'(if_valid), 32'h0);
    if_req  = 1'b1;
    if_addr = 32'h600;
    dm_req  = 1'b1;
    dm_addr = 32'h700;
    step();
    chk("post_rst_prio", mem_addr, 32'h600);
    mem_ack   = 1'b1;
    mem_rdata = 32'h99;
    if_req    = 1'b0;
    dm_req    = 1'b0;
    step();
    chk("post_rst_ifv",   32'(if_valid), 32'h1);
    chk("post_rst_rdata", if_rdata,      32'h99);
    mem_ack = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
